exc_commit_ctrl: RTL and testbench
==================================

// Module: exc_commit_ctrl
// PURPOSE
//  Exception/ERET commit sequencer at the WB stage. Merges per-instruction exception flags
//  with the pending CP0 interrupt and picks the highest-priority cause. Pulses the CP0
//  update strobes (wb_ex/excode/badvaddr, eret_flush), flushes the pipeline for a fixed
//  drain period, then hands the fetch redirect (exception entry or EPC) to IF via valid/ready.
// PARAMETERS
//  EX_ENTRY   32'hbfc00380  exception vector (BEV=1)
//  FLUSH_CYC  2             cycles pipe_flush stays high after the trigger cycle (>=1)
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, asynchronous, active-high
//  wb_valid        in   1   WB holds a valid instruction this cycle
//  wb_pc           in   32  PC of WB instruction
//  wb_bd           in   1   WB instruction is in a branch delay slot
//  wb_exflags      in   6   {adel_if, ri, ov, sys, bp, adel_ades_mem}
//  wb_mem_we       in   1   mem access is a store (selects ADES vs ADEL)
//  wb_mem_addr     in   32  faulting data address
//  wb_eret         in   1   WB instruction is ERET
//  has_int         in   1   CP0 interrupt request (already masked by IE/EXL/IM)
//  c0_epc          in   32  current EPC from CP0
//  redirect_ready  in   1   IF accepts redirect
//  wb_allowin      out  1   WB may commit; 0 while sequencing
//  wb_ex           out  1   1-cycle strobe to CP0: take exception
//  wb_ex_bd        out  1   BD bit for CP0, valid with wb_ex
//  wb_ex_pc        out  32  PC for EPC, valid with wb_ex
//  wb_excode       out  5   cause code, valid with wb_ex
//  wb_badvaddr     out  32  BadVAddr, valid with wb_ex
//  eret_flush      out  1   1-cycle strobe to CP0: clear EXL
//  pipe_flush      out  1   kill all younger stages
//  redirect_valid  out  1   redirect target valid
//  redirect_pc     out  32  new fetch PC
// BEHAVIOUR
//  Reset: state=RUN, int_pend=0, all outputs 0 except wb_allowin=1.
//  int_pend: set when has_int=1, cleared when has_int=0 or interrupt is taken; taken only
//   with an instruction (wb_valid=1) in WB, attached to that instruction (EPC=its PC).
//  Priority (high->low): INT(0) > ADEL_IF(4) > RI(10) > OV(12) > SYS(8) > BP(9) >
//   mem ADEL(4)/ADES(5 if wb_mem_we). ERET only if no cause is present.
//  BadVAddr: ADEL_IF -> wb_pc; mem ADEL/ADES -> wb_mem_addr; otherwise 0.
//  FSM RUN: wb_valid & cause -> wb_ex=1 same cycle (comb), target=EX_ENTRY, ->FLUSH.
//   wb_valid & eret & no cause -> eret_flush=1 same cycle, target latched = c0_epc
//   (sampled that cycle, before CP0 updates), ->FLUSH. Else stay.
//   Trigger cycle: pipe_flush=1, wb_allowin=0.
//  FLUSH: pipe_flush=1, wb_allowin=0, counter counts FLUSH_CYC cycles, then ->REDIRECT.
//  REDIRECT: redirect_valid=1, redirect_pc=latched target, held stable until
//   redirect_ready; on handshake ->RUN next cycle. pipe_flush=0, wb_allowin=0.
//  Outside RUN: wb_valid/wb_exflags/wb_eret/has_int ignored for triggering; wb_ex and
//   eret_flush never asserted; int_pend keeps tracking has_int.
//  wb_ex and eret_flush are mutually exclusive and each high at most 1 cycle per event.
//  wb_ex_bd=wb_bd, wb_ex_pc=wb_pc (CP0 does the -4 for BD).
//  rst mid-sequence: immediate return to reset state; latched target discarded.
// STRUCTURE
//  EX_* codes and FSM state encodings in mycpu.h (shared with CP0 regfile).
//  Sub-module exc_prio_enc: combinational flags+int -> {has_cause, excode, badv_sel}.
// TESTING
//  1 wb_valid, ri=1, pc=0xbfc00100 -> wb_ex 1 cycle, excode=10, flush 1+2 cycles,
//    redirect_pc=0xbfc00380 held until ready, wb_allowin=1 after.
//  2 wb_valid, mem addr 0x80000003, store -> excode=5, badvaddr=0x80000003.
//  3 has_int=1 with wb_valid=0 for 3 cycles, then wb_valid pc=0xbfc00200 with sys=1 ->
//    excode=0, wb_ex_pc=0xbfc00200; has_int drop before wb_valid -> no exception.
//  4 eret, c0_epc=0xbfc00500 -> eret_flush 1 cycle, no wb_ex, redirect_pc=0xbfc00500.
//  5 eret together with ov=1 -> wb_ex excode=12, eret_flush stays 0.
//  6 redirect_ready held 0 for 5 cycles, then rst pulse -> redirect_valid=0, state RUN.

Source files
------------

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the WB-stage exception/ERET commit sequencer.
// The cause codes must stay in sync with the CP0 Cause.ExcCode encoding.
package exc_commit_ctrl_pkg;

    localparam logic [4:0] EX_INT  = 5'd0;
    localparam logic [4:0] EX_ADEL = 5'd4;
    localparam logic [4:0] EX_ADES = 5'd5;
    localparam logic [4:0] EX_SYS  = 5'd8;
    localparam logic [4:0] EX_BP   = 5'd9;
    localparam logic [4:0] EX_RI   = 5'd10;
    localparam logic [4:0] EX_OV   = 5'd12;

    // Bit positions inside wb_exflags.
    localparam int EXF_ADEL_IF = 5;
    localparam int EXF_RI      = 4;
    localparam int EXF_OV      = 3;
    localparam int EXF_SYS     = 2;
    localparam int EXF_BP      = 1;
    localparam int EXF_MEM     = 0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BADV_NONE = 2'd0,
        BADV_PC   = 2'd1,
        BADV_MEM  = 2'd2
    } badv_sel_e;

    typedef struct packed {
        logic      has_cause;
        logic [4:0] excode;
        badv_sel_e badv_sel;
    } prio_t;

endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Combinational cause picker: pending interrupt plus per-instruction flags
// reduced to the single highest-priority exception and its BadVAddr source.
module exc_commit_ctrl_prio_enc
    import exc_commit_ctrl_pkg::*;
(
    input  logic       int_pend,
    input  logic [5:0] exflags,
    input  logic       mem_we,
    output prio_t      prio
);

    always_comb begin
        prio = '{has_cause: 1'b1, excode: EX_INT, badv_sel: BADV_NONE};
        if (int_pend) begin
            prio.excode = EX_INT;
        end else if (exflags[EXF_ADEL_IF]) begin
            prio.excode   = EX_ADEL;
            prio.badv_sel = BADV_PC;
        end else if (exflags[EXF_RI]) begin
            prio.excode = EX_RI;
        end else if (exflags[EXF_OV]) begin
            prio.excode = EX_OV;
        end else if (exflags[EXF_SYS]) begin
            prio.excode = EX_SYS;
        end else if (exflags[EXF_BP]) begin
            prio.excode = EX_BP;
        end else if (exflags[EXF_MEM]) begin
            // One flag covers both data-side address errors; the access type splits them.
            prio.excode   = mem_we ? EX_ADES : EX_ADEL;
            prio.badv_sel = BADV_MEM;
        end else begin
            prio.has_cause = 1'b0;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// WB-stage exception/ERET commit sequencer: strobes CP0, drains the pipe for a
// fixed number of cycles, then hands the fetch redirect to IF via valid/ready.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY  = 32'hbfc00380,
    parameter int          FLUSH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_bd,
    input  logic [5:0]  wb_exflags,
    input  logic        wb_mem_we,
    input  logic [31:0] wb_mem_addr,
    input  logic        wb_eret,
    input  logic        has_int,
    input  logic [31:0] c0_epc,
    input  logic        redirect_ready,
    output logic        wb_allowin,
    output logic        wb_ex,
    output logic        wb_ex_bd,
    output logic [31:0] wb_ex_pc,
    output logic [4:0]  wb_excode,
    output logic [31:0] wb_badvaddr,
    output logic        eret_flush,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int CNT_W = $clog2(FLUSH_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      target_q, target_d;
    logic             int_pend_q, int_pend_d;

    prio_t prio;
    logic  trig_ex, trig_eret;

    exc_commit_ctrl_prio_enc u_prio (
        .int_pend (int_pend_q),
        .exflags  (wb_exflags),
        .mem_we   (wb_mem_we),
        .prio     (prio)
    );

    // Masked by rst so the async reset window never leaks a strobe to CP0.
    assign trig_ex   = ~rst && state_q == ST_RUN && wb_valid && prio.has_cause;
    assign trig_eret = ~rst && state_q == ST_RUN && wb_valid && wb_eret && !prio.has_cause;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            target_q   <= '0;
            int_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            int_pend_q <= int_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        // A taken interrupt is consumed even if has_int is still high this cycle.
        int_pend_d = has_int && !(trig_ex && int_pend_q);
        case (state_q)
            ST_RUN: begin
                if (trig_ex) begin
                    state_d  = ST_FLUSH;
                    cnt_d    = '0;
                    target_d = EX_ENTRY;
                end else if (trig_eret) begin
                    state_d  = ST_FLUSH;
                    cnt_d    = '0;
                    target_d = c0_epc;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CNT_LAST) state_d = ST_REDIRECT;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            ST_REDIRECT: begin
                if (redirect_ready) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        wb_allowin     = 1'b0;
        wb_ex          = 1'b0;
        wb_ex_bd       = 1'b0;
        wb_ex_pc       = '0;
        wb_excode      = '0;
        wb_badvaddr    = '0;
        eret_flush     = 1'b0;
        pipe_flush     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            ST_RUN: begin
                wb_allowin = !(trig_ex || trig_eret);
                pipe_flush = trig_ex || trig_eret;
                eret_flush = trig_eret;
                wb_ex      = trig_ex;
                if (trig_ex) begin
                    wb_ex_bd  = wb_bd;
                    wb_ex_pc  = wb_pc;
                    wb_excode = prio.excode;
                    case (prio.badv_sel)
                        BADV_PC:  wb_badvaddr = wb_pc;
                        BADV_MEM: wb_badvaddr = wb_mem_addr;
                        default:  wb_badvaddr = '0;
                    endcase
                end
            end
            ST_FLUSH: pipe_flush = 1'b1;
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed scenarios plus randomized events checked
// against a priority-list reference model.
module tb_exc_commit_ctrl;

    localparam logic [31:0] EX_ENTRY  = 32'hbfc00380;
    localparam int          FLUSH_CYC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic        wb_bd = 1'b0;
    logic [5:0]  wb_exflags = '0;
    logic        wb_mem_we = 1'b0;
    logic [31:0] wb_mem_addr = '0;
    logic        wb_eret = 1'b0;
    logic        has_int = 1'b0;
    logic [31:0] c0_epc = '0;
    logic        redirect_ready = 1'b0;
    logic        wb_allowin, wb_ex, wb_ex_bd, eret_flush, pipe_flush, redirect_valid;
    logic [31:0] wb_ex_pc, wb_badvaddr, redirect_pc;
    logic [4:0]  wb_excode;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exc_commit_ctrl #(.EX_ENTRY(EX_ENTRY), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_bd(wb_bd),
        .wb_exflags(wb_exflags), .wb_mem_we(wb_mem_we), .wb_mem_addr(wb_mem_addr),
        .wb_eret(wb_eret), .has_int(has_int), .c0_epc(c0_epc),
        .redirect_ready(redirect_ready), .wb_allowin(wb_allowin), .wb_ex(wb_ex),
        .wb_ex_bd(wb_ex_bd), .wb_ex_pc(wb_ex_pc), .wb_excode(wb_excode),
        .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush), .pipe_flush(pipe_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Reference: first present cause in priority order -> {has, code, badvaddr}.
    function automatic logic [37:0] ref_cause(input logic hi, input logic [5:0] f,
                                              input logic we, input logic [31:0] pc,
                                              input logic [31:0] addr);
        logic present [7];
        int   code    [7];
        present = '{hi, f[5], f[4], f[3], f[2], f[1], f[0]};
        code    = '{0, 4, 10, 12, 8, 9, (we ? 5 : 4)};
        for (int i = 0; i < 7; i++)
            if (present[i])
                return {1'b1, 5'(code[i]), (i == 1) ? pc : (i == 6) ? addr : 32'h0};
        return '0;
    endfunction

    task automatic go_idle();
        @(posedge clk); #1;
        wb_valid = 1'b0; wb_eret = 1'b0; wb_exflags = '0; redirect_ready = 1'b0;
    endtask

    // One full commit event: setup with has_int held, trigger cycle, drain, redirect.
    task automatic run_event(input string nm, input logic hi, input logic [5:0] fl,
                             input logic er, input logic we, input logic bd,
                             input logic [31:0] pc, input logic [31:0] addr,
                             input logic [31:0] epc, input int rdly);
        logic [37:0] r;
        logic        trig;
        logic [31:0] tgt;
        @(posedge clk); #1;
        has_int = hi; wb_valid = 1'b0; wb_exflags = fl; wb_eret = er;
        wb_mem_we = we; wb_bd = bd; redirect_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({wb_ex, eret_flush, pipe_flush, wb_allowin} !== 4'b0001) begin
            bad++;
            $display("FAIL %s idle: got %b want 0001", nm, {wb_ex, eret_flush, pipe_flush, wb_allowin});
        end
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_pc = pc; wb_mem_addr = addr; c0_epc = epc;
        r    = ref_cause(hi, fl, we, pc, addr);
        trig = r[37] | er;
        tgt  = r[37] ? EX_ENTRY : epc;
        @(negedge clk);
        total++;
        if ({wb_ex, eret_flush, pipe_flush, wb_allowin} !== {r[37], ~r[37] & er, trig, ~trig}) begin
            bad++;
            $display("FAIL %s trigger: got %b want %b", nm,
                     {wb_ex, eret_flush, pipe_flush, wb_allowin}, {r[37], ~r[37] & er, trig, ~trig});
        end
        if (r[37]) begin
            total++;
            if ({wb_ex_bd, wb_ex_pc, wb_excode, wb_badvaddr} !== {bd, pc, r[36:0]}) begin
                bad++;
                $display("FAIL %s cp0 fields: got bd=%b pc=%h code=%0d badv=%h want bd=%b pc=%h code=%0d badv=%h",
                         nm, wb_ex_bd, wb_ex_pc, wb_excode, wb_badvaddr, bd, pc, r[36:32], r[31:0]);
            end
        end
        if (!trig) begin
            go_idle();
            return;
        end
        for (int i = 0; i < FLUSH_CYC; i++) begin
            @(posedge clk); #1;
            wb_valid = 1'($urandom); wb_eret = 1'b1; wb_exflags = 6'($urandom); c0_epc = $urandom;
            @(negedge clk);
            total++;
            if ({wb_ex, eret_flush, pipe_flush, wb_allowin, redirect_valid} !== 5'b00100) begin
                bad++;
                $display("FAIL %s flush%0d: got %b want 00100", nm, i,
                         {wb_ex, eret_flush, pipe_flush, wb_allowin, redirect_valid});
            end
        end
        for (int i = 0; i <= rdly; i++) begin
            @(posedge clk); #1;
            redirect_ready = (i == rdly);
            @(negedge clk);
            total++;
            if ({wb_ex, eret_flush, pipe_flush, wb_allowin, redirect_valid, redirect_pc} !== {5'b00001, tgt}) begin
                bad++;
                $display("FAIL %s redirect%0d: got ctl=%b pc=%h want ctl=00001 pc=%h", nm, i,
                         {wb_ex, eret_flush, pipe_flush, wb_allowin, redirect_valid}, redirect_pc, tgt);
            end
        end
        go_idle();
        @(negedge clk);
        total++;
        if ({redirect_valid, pipe_flush, wb_allowin} !== 3'b001) begin
            bad++;
            $display("FAIL %s back_to_run: got %b want 001", nm, {redirect_valid, pipe_flush, wb_allowin});
        end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        total++;
        if ({wb_allowin, wb_ex, wb_ex_bd, wb_ex_pc, wb_excode, wb_badvaddr, eret_flush,
             pipe_flush, redirect_valid, redirect_pc} !== {1'b1, 106'b0}) begin
            bad++;
            $display("FAIL reset: allowin=%b ex=%b eret=%b flush=%b rv=%b rpc=%h want only allowin=1",
                     wb_allowin, wb_ex, eret_flush, pipe_flush, redirect_valid, redirect_pc);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_event("ri",       1'b0, 6'b010000, 1'b0, 1'b0, 1'b0, 32'hbfc00100, 32'h0, 32'h0, 4);
        run_event("ades",     1'b0, 6'b000001, 1'b0, 1'b1, 1'b0, 32'hbfc00104, 32'h80000003, 32'h0, 0);
        run_event("adel_mem", 1'b0, 6'b000001, 1'b0, 1'b0, 1'b1, 32'hbfc00108, 32'h80000001, 32'h0, 1);
        run_event("int_sys",  1'b1, 6'b000100, 1'b0, 1'b0, 1'b0, 32'hbfc00200, 32'h0, 32'h0, 0);
        run_event("eret",     1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 32'hbfc00300, 32'h0, 32'hbfc00500, 2);
        run_event("eret_ov",  1'b0, 6'b001000, 1'b1, 1'b0, 1'b0, 32'hbfc00304, 32'h0, 32'hbfc00500, 0);
        run_event("adel_if",  1'b0, 6'b111111, 1'b0, 1'b1, 1'b1, 32'hbfc00002, 32'h12345678, 32'h0, 1);
        run_event("nothing",  1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 32'hbfc00400, 32'h0, 32'h0, 0);
    endtask

    task automatic test_int_drop();
        @(posedge clk); #1;
        has_int = 1'b1; wb_valid = 1'b0; wb_exflags = '0; wb_eret = 1'b0;
        repeat (3) @(posedge clk);
        #1 has_int = 1'b0;
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_pc = 32'hbfc00200;
        @(negedge clk);
        total++;
        if ({wb_ex, pipe_flush, wb_allowin} !== 3'b001) begin
            bad++;
            $display("FAIL int_drop: got %b want 001", {wb_ex, pipe_flush, wb_allowin});
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        run_event("pre_rst", 1'b0, 6'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_eret = 1'b1; c0_epc = 32'hbfc00700;
        @(posedge clk); #1;
        wb_valid = 1'b0; wb_eret = 1'b0;
        repeat (FLUSH_CYC + 5) @(posedge clk);
        @(negedge clk);
        total++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'hbfc00700}) begin
            bad++;
            $display("FAIL rst_mid stall: got rv=%b pc=%h want rv=1 pc=bfc00700", redirect_valid, redirect_pc);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        total++;
        if ({redirect_valid, pipe_flush, wb_allowin, redirect_pc} !== {3'b001, 32'h0}) begin
            bad++;
            $display("FAIL rst_mid async: got %b pc=%h want 001 pc=0", {redirect_valid, pipe_flush, wb_allowin}, redirect_pc);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if ({redirect_valid, pipe_flush, wb_allowin} !== 3'b001) begin
            bad++;
            $display("FAIL rst_mid after: got %b want 001", {redirect_valid, pipe_flush, wb_allowin});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [5:0] fl;
            fl = 6'($urandom) & 6'($urandom) & 6'($urandom);
            run_event("rand", ($urandom_range(0, 3) == 0), fl, 1'($urandom), 1'($urandom),
                      1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_int_drop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
